// File: rtl/display_scan_driver.sv
// 8-digit multiplexed 7-segment driver: hex or double-dabble decimal value
// on d0..d4, status on d7. Option macro: LEADING_ZERO_BLANK_EN.
// Ports: clk, reset (async, active-low), load, value, status, mode,
//        busy, an (active-low one-hot), seg {g..a} (active-low), dp (off).
module display_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int VALUE_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [VALUE_W-1:0] value,
  input  logic [2:0]         status,
  input  logic               mode,
  output logic               busy,
  output logic [7:0]         an,
  output logic [6:0]         seg,
  output logic               dp
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] RC_TOP = CW'(REFRESH_DIV - 1);

  // digit code: bit 4 set means blank
  localparam logic [4:0] BLANK = 5'h10;

  logic [1:0]         state;
  logic [3:0]         cnt;
  logic [19:0]        bcd;
  logic [19:0]        adj;
  logic [VALUE_W-1:0] bin;
  logic [2:0]         cap_stat;
  logic               hex_pend;

  logic [7:0][4:0]    dig;
  logic [7:0][4:0]    hex_d;
  logic [7:0][4:0]    dec_d;

  logic [CW-1:0]      rcnt;
  logic [2:0]         idx;

  assign busy = (state == S_SHIFT);
  assign dp   = 1'b1;

  function automatic logic [6:0] seg7(input logic [4:0] d);
    logic [6:0] s;
    s = 7'h7F;
    if (!d[4]) begin
      case (d[3:0])
        4'h0: s = 7'b1000000;
        4'h1: s = 7'b1111001;
        4'h2: s = 7'b0100100;
        4'h3: s = 7'b0110000;
        4'h4: s = 7'b0011001;
        4'h5: s = 7'b0010010;
        4'h6: s = 7'b0000010;
        4'h7: s = 7'b1111000;
        4'h8: s = 7'b0000000;
        4'h9: s = 7'b0010000;
        4'hA: s = 7'b0001000;
        4'hB: s = 7'b0000011;
        4'hC: s = 7'b1000110;
        4'hD: s = 7'b0100001;
        4'hE: s = 7'b0000110;
        default: s = 7'b0001110;
      endcase
    end
    return s;
  endfunction

  // add-3 correction ahead of each shift
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic lz;
`endif
    hex_d = {8{BLANK}};
    for (int i = 0; i < 4; i++)
      hex_d[i] = {1'b0, bin[4*i +: 4]};
    hex_d[7] = {2'b00, cap_stat};
`ifdef LEADING_ZERO_BLANK_EN
    lz = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (hex_d[i][3:0] != 4'd0) lz = 1'b0;
      if (lz) hex_d[i] = BLANK;
    end
`endif
  end

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic lz;
`endif
    dec_d = {8{BLANK}};
    for (int i = 0; i < 5; i++)
      dec_d[i] = {1'b0, bcd[4*i +: 4]};
    dec_d[7] = {2'b00, cap_stat};
`ifdef LEADING_ZERO_BLANK_EN
    lz = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      if (dec_d[i][3:0] != 4'd0) lz = 1'b0;
      if (lz) dec_d[i] = BLANK;
    end
`endif
  end

  // capture and converter; a new load always restarts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bcd      <= '0;
      bin      <= '0;
      cap_stat <= '0;
      hex_pend <= 1'b0;
    end else begin
      hex_pend <= 1'b0;
      if (load) begin
        bin      <= value;
        cap_stat <= status;
        bcd      <= '0;
        cnt      <= '0;
        if (mode) begin
          state <= S_SHIFT;
        end else begin
          state    <= S_IDLE;
          hex_pend <= 1'b1;
        end
      end else begin
        unique case (state)
          S_SHIFT: begin
            bcd <= {adj[18:0], bin[VALUE_W-1]};
            bin <= {bin[VALUE_W-2:0], 1'b0};
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) state <= S_DONE;
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // shadowed digit registers; whole field swaps on one edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dig <= {8{BLANK}};
    end else begin
      if (!busy) dig[7] <= {2'b00, status};
      if (hex_pend)
        dig <= hex_d;
      else if (state == S_DONE)
        dig <= dec_d;
    end
  end

  // an and seg both registered from idx so they never skew
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rcnt <= '0;
      idx  <= '0;
      an   <= 8'hFF;
      seg  <= 7'h7F;
    end else begin
      an  <= ~(8'd1 << idx);
      seg <= seg7(dig[idx]);
      if (rcnt == RC_TOP) begin
        rcnt <= '0;
        idx  <= idx + 3'd1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Randomized bench for display_scan_driver against a digit-level model.
// Checks an/seg/busy/dp every cycle; honours LEADING_ZERO_BLANK_EN.
module tb_display_scan_driver;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [2:0]  status;
  logic        mode;
  logic        busy;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  display_scan_driver #(
    .REFRESH_DIV(RD),
    .VALUE_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .value(value),
    .status(status),
    .mode(mode),
    .busy(busy),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  localparam logic [4:0] BL = 5'h10;

  int          k;
  int          hex_at;
  int          dec_at;
  logic [15:0] p_val;
  logic [2:0]  p_stat;
  logic [4:0]  m_dig [8];
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_busy;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               tag, $time, got, exp);
    end
  endtask

  function automatic logic [6:0] dec7(logic [4:0] d);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    if (d[4]) return 7'h7F;
    return t[d[3:0]];
  endfunction

  task automatic model_reset();
    k      = 0;
    hex_at = -1;
    dec_at = -1;
    for (int i = 0; i < 8; i++) m_dig[i] = BL;
    e_an   = 8'hFF;
    e_seg  = 7'h7F;
    e_busy = 1'b0;
  endtask

  task automatic model_step();
    logic [4:0] prev [8];
    logic [4:0] nd [8];
    int idx;
    int t;
    int nfld;
    bit lz;
    k++;
    prev  = m_dig;
    idx   = ((k - 1) / RD) % 8;
    e_an  = ~(8'd1 << idx);
    e_seg = dec7(prev[idx]);
    if (!e_busy) m_dig[7] = {2'b00, status};
    if (k == hex_at || k == dec_at) begin
      for (int i = 0; i < 8; i++) nd[i] = BL;
      t = int'(p_val);
      if (k == hex_at) begin
        nfld = 4;
        for (int i = 0; i < 4; i++) begin
          nd[i] = {1'b0, 4'(t % 16)};
          t = t / 16;
        end
      end else begin
        nfld = 5;
        for (int i = 0; i < 5; i++) begin
          nd[i] = {1'b0, 4'(t % 10)};
          t = t / 10;
        end
      end
      lz = 1'b1;
      for (int i = nfld - 1; i >= 1; i--) begin
        if (nd[i] != 5'd0) lz = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (lz) nd[i] = BL;
`endif
      end
      nd[7] = {2'b00, p_stat};
      m_dig = nd;
      hex_at = -1;
      dec_at = -1;
    end
    if (load) begin
      p_val  = value;
      p_stat = status;
      if (mode) begin
        dec_at = k + 17;
        hex_at = -1;
      end else begin
        hex_at = k + 1;
        dec_at = -1;
      end
    end
    e_busy = (dec_at >= 0) && (k <= dec_at - 2);
  endtask

  always @(posedge clk) if (reset) model_step();

  task automatic check_outs();
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("dp", 32'(dp), 32'd1);
  endtask

  task automatic cyc();
    @(negedge clk);
    check_outs();
  endtask

  task automatic do_load(logic [15:0] v, logic m,
                         logic [2:0] s);
    value  = v;
    mode   = m;
    status = s;
    load   = 1'b1;
    cyc();
    load   = 1'b0;
  endtask

  initial begin
    reset  = 1'b0;
    load   = 1'b0;
    value  = '0;
    mode   = 1'b0;
    status = '0;
    model_reset();
    repeat (3) cyc();
    reset = 1'b1;
    repeat (32) cyc();

    do_load(16'h003F, 1'b0, 3'd2);
    repeat (40) cyc();

    do_load(16'd12345, 1'b1, 3'd2);
    repeat (40) cyc();

    do_load(16'hFFFF, 1'b1, 3'd5);
    repeat (4) cyc();
    do_load(16'd42, 1'b1, 3'd5);
    repeat (40) cyc();

    for (int n = 0; n < 30; n++) begin
      int gap;
      logic [15:0] v;
      gap = $urandom_range(0, 22);
      if ($urandom_range(0, 2) == 0)
        v = 16'($urandom_range(0, 20));
      else
        v = 16'($urandom);
      do_load(v, 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)));
      repeat (gap) begin
        if ($urandom_range(0, 7) == 0)
          status = 3'($urandom_range(0, 7));
        cyc();
      end
    end
    repeat (40) cyc();

    do_load(16'd9999, 1'b1, 3'd1);
    repeat (7) cyc();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_outs();
    cyc();
    reset = 1'b1;
    repeat (20) cyc();

    do_load(16'h0000, 1'b0, 3'd3);
    repeat (40) cyc();
    do_load(16'd7, 1'b1, 3'd4);
    repeat (50) cyc();
    do_load(16'd0, 1'b1, 3'd6);
    repeat (50) cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
